// File: rtl/vec_frame_acc_if.sv
// Handshake bundle for vec_frame_acc: per-timestep input vector stream in,
// frame-sum/argmax result out.
interface vec_frame_acc_if #(
    parameter int unsigned BW_I       = 33,
    parameter int unsigned BW_O       = 40,
    parameter int unsigned VECTOR_LEN = 13,
    parameter int unsigned CNT_BW     = 8
);
    localparam int unsigned IDX_BW = $clog2(VECTOR_LEN);

    logic [VECTOR_LEN*BW_I-1:0] data_i;
    logic                       valid_i;
    logic                       last_i;
    logic                       ready_o;
    logic [VECTOR_LEN*BW_O-1:0] data_o;
    logic [IDX_BW-1:0]          argmax_o;
    logic [CNT_BW-1:0]          count_o;
    logic                       overflow_o;
    logic                       valid_o;
    logic                       ready_i;

    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, argmax_o, count_o, overflow_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, argmax_o, count_o, overflow_o, valid_o
    );
endinterface

// File: rtl/vec_frame_acc.sv
// Frame accumulator: element-wise saturating sum of input vectors over a frame,
// then a sequential argmax scan, then a held result behind valid/ready.
module vec_frame_acc #(
    parameter int unsigned BW_I       = 33,
    parameter int unsigned BW_O       = 40,
    parameter int unsigned VECTOR_LEN = 13,
    parameter int unsigned CNT_BW     = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    vec_frame_acc_if.slave bus
);
    localparam int unsigned IDX_BW = $clog2(VECTOR_LEN);
    localparam int unsigned SUM_W  = BW_O + 1;
    localparam logic signed [BW_O-1:0] SAT_MAX = {1'b0, {(BW_O-1){1'b1}}};
    localparam logic signed [BW_O-1:0] SAT_MIN = {1'b1, {(BW_O-1){1'b0}}};

    typedef enum logic [1:0] {ST_ACC, ST_SCAN, ST_OUT} state_e;

    state_e                 state_q, state_d;
    logic signed [BW_O-1:0] acc_q   [VECTOR_LEN];
    logic signed [BW_O-1:0] acc_sat [VECTOR_LEN];
    logic [VECTOR_LEN-1:0]  clamp;
    logic signed [BW_O-1:0] best_val_q;
    logic [IDX_BW-1:0]      best_idx_q;
    logic [IDX_BW-1:0]      scan_k_q;
    logic [CNT_BW-1:0]      count_q;
    logic                   overflow_q;
    logic                   valid_q;
    logic                   beat;
    logic                   scan_done;
    logic                   out_fire;

    // Ready is a decode of the state register, forced low while reset is held.
    assign bus.ready_o = (state_q == ST_ACC) && !rst_i;
    assign beat        = bus.valid_i && bus.ready_o;
    assign scan_done   = (state_q == ST_SCAN) && (scan_k_q == IDX_BW'(VECTOR_LEN - 1));
    assign out_fire    = valid_q && bus.ready_i;

    for (genvar g = 0; g < VECTOR_LEN; g++) begin : g_elem
        logic signed [BW_I-1:0]  elem;
        logic signed [SUM_W-1:0] sum;

        // One extra sum bit makes overflow visible as a top-two-bit mismatch.
        assign elem     = bus.data_i[g*BW_I +: BW_I];
        assign sum      = SUM_W'(acc_q[g]) + SUM_W'(elem);
        assign clamp[g] = sum[SUM_W-1] != sum[SUM_W-2];
        assign acc_sat[g] = clamp[g] ? (sum[SUM_W-1] ? SAT_MIN : SAT_MAX)
                                     : sum[BW_O-1:0];
        assign bus.data_o[g*BW_O +: BW_O] = acc_q[g];
    end

    assign bus.argmax_o   = best_idx_q;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = overflow_q;
    assign bus.valid_o    = valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ACC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == ST_OUT);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACC:  if (beat && bus.last_i) state_d = ST_SCAN;
            ST_SCAN: if (scan_done)          state_d = ST_OUT;
            ST_OUT:  if (out_fire)           state_d = ST_ACC;
            default:                         state_d = ST_ACC;
        endcase
    end

    // Accumulate, scan and clear; the result registers double as outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < VECTOR_LEN; i++) acc_q[i] <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= '0;
            scan_k_q   <= '0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (beat) begin
                        acc_q      <= acc_sat;
                        count_q    <= (&count_q) ? count_q : count_q + 1'b1;
                        overflow_q <= overflow_q | (|clamp);
                        scan_k_q   <= '0;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps the lower index on ties.
                    if ((scan_k_q == '0) || (acc_q[scan_k_q] > best_val_q)) begin
                        best_val_q <= acc_q[scan_k_q];
                        best_idx_q <= scan_k_q;
                    end
                    scan_k_q <= scan_k_q + 1'b1;
                end
                ST_OUT: begin
                    if (out_fire) begin
                        for (int i = 0; i < VECTOR_LEN; i++) acc_q[i] <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        best_val_q <= '0;
                        best_idx_q <= '0;
                        scan_k_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_frame_acc.sv
// Scoreboard bench for vec_frame_acc: a reference model pushes the expected
// frame result on each last beat; test tasks pop and compare when valid_o rises.
module tb_vec_frame_acc;
    localparam int unsigned BW_I   = 33;
    localparam int unsigned BW_O   = 40;
    localparam int unsigned VL     = 13;
    localparam int unsigned CNT_BW = 8;
    localparam int unsigned IDX_BW = $clog2(VL);
    localparam longint SMAX = (longint'(1) <<< (BW_O - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (BW_O - 1));
    localparam int     CMAX = (1 << CNT_BW) - 1;

    typedef logic [VL*BW_I-1:0] vin_t;
    typedef logic [VL*BW_O-1:0] vout_t;
    typedef struct {
        vout_t             data;
        logic [IDX_BW-1:0] idx;
        logic [CNT_BW-1:0] cnt;
        logic              ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exp_t   q[$];
    longint m_acc[VL];
    int     m_cnt;
    bit     m_ovf;

    vec_frame_acc_if #(.BW_I(BW_I), .BW_O(BW_O), .VECTOR_LEN(VL), .CNT_BW(CNT_BW)) bus ();

    vec_frame_acc #(.BW_I(BW_I), .BW_O(BW_O), .VECTOR_LEN(VL), .CNT_BW(CNT_BW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vin_t fill(input longint val);
        vin_t r;
        for (int i = 0; i < VL; i++) r[i*BW_I +: BW_I] = BW_I'(val);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < VL; i++) m_acc[i] = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Reference: saturating add on 64-bit longints, then strict-greater argmax.
    task automatic model_beat(input vin_t v, input bit last);
        logic signed [BW_I-1:0] e;
        longint s;
        longint best;
        exp_t   ex;
        for (int i = 0; i < VL; i++) begin
            e = v[i*BW_I +: BW_I];
            s = m_acc[i] + longint'(e);
            if (s > SMAX) begin s = SMAX; m_ovf = 1'b1; end
            else if (s < SMIN) begin s = SMIN; m_ovf = 1'b1; end
            m_acc[i] = s;
        end
        if (m_cnt < CMAX) m_cnt++;
        if (last) begin
            best   = m_acc[0];
            ex.idx = '0;
            for (int i = 0; i < VL; i++) begin
                ex.data[i*BW_O +: BW_O] = BW_O'(m_acc[i]);
                if (m_acc[i] > best) begin best = m_acc[i]; ex.idx = IDX_BW'(i); end
            end
            ex.cnt = CNT_BW'(m_cnt);
            ex.ovf = m_ovf;
            q.push_back(ex);
            model_clear();
        end
    endtask

    // Entered and left at 1 ns after a rising edge.
    task automatic send_beat(input vin_t v, input bit last);
        bus.data_i  = v;
        bus.valid_i = 1'b1;
        bus.last_i  = last;
        for (int n = 0; n < 200; n++) begin
            if (bus.ready_o) begin
                @(posedge clk); #1;
                model_beat(v, last);
                bus.valid_i = 1'b0;
                bus.last_i  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL send_beat: ready_o never rose within 200 cycles");
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic idle(input int n, input bit last_level);
        bus.valid_i = 1'b0;
        bus.last_i  = last_level;
        repeat (n) begin @(posedge clk); #1; end
        bus.last_i  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.last_i = 1'b0; bus.ready_i = 1'b1;
        bus.data_i = fill(1);
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.valid_o !== 1'b0)   begin failures++; $display("FAIL reset valid_o got %b want 0", bus.valid_o); end
        if (bus.ready_o !== 1'b0)   begin failures++; $display("FAIL reset ready_o got %b want 0", bus.ready_o); end
        if (bus.data_o !== '0)      begin failures++; $display("FAIL reset data_o got %h want 0", bus.data_o); end
        if ({bus.argmax_o, bus.count_o} !== '0) begin failures++; $display("FAIL reset argmax/count got %0d/%0d want 0/0", bus.argmax_o, bus.count_o); end
        if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL reset overflow_o got %b want 0", bus.overflow_o); end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_release ready_o got %b want 1", bus.ready_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int   lat;
        exp_t e;
        send_beat(fill(5), 1'b0);
        send_beat(fill(7), 1'b0);
        send_beat(fill(-2), 1'b1);
        wait_valid(lat);
        checks += 2;
        if (!bus.valid_o || q.size() == 0) begin
            failures += 2; $display("FAIL basic valid_o got %b want 1 (timeout)", bus.valid_o);
        end else begin
            e = q.pop_front();
            if (lat != VL) begin failures++; $display("FAIL basic latency got %0d want %0d", lat, VL); end
            checks += 3;
            if (bus.data_o !== e.data) begin failures++; $display("FAIL basic data_o got %h want %h", bus.data_o, e.data); end
            if (bus.count_o !== e.cnt || bus.overflow_o !== e.ovf) begin failures++; $display("FAIL basic count/ovf got %0d/%b want %0d/%b", bus.count_o, bus.overflow_o, e.cnt, e.ovf); end
            if (bus.argmax_o !== e.idx) begin failures++; $display("FAIL basic argmax got %0d want %0d", bus.argmax_o, e.idx); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_argmax();
        int   lat;
        exp_t e;
        vin_t v;
        for (int r = 0; r < 2; r++) begin
            v = fill(-1);
            v[4*BW_I +: BW_I] = BW_I'(100);
            v[9*BW_I +: BW_I] = BW_I'(100 + r);
            send_beat(v, 1'b1);
            wait_valid(lat);
            checks++;
            if (!bus.valid_o || q.size() == 0) begin
                failures++; $display("FAIL argmax%0d valid_o got %b want 1 (timeout)", r, bus.valid_o);
            end else begin
                e = q.pop_front();
                checks += 2;
                if (bus.argmax_o !== e.idx) begin failures++; $display("FAIL argmax%0d argmax_o got %0d want %0d", r, bus.argmax_o, e.idx); end
                if (bus.data_o !== e.data || bus.count_o !== e.cnt) begin failures++; $display("FAIL argmax%0d data/count got %h/%0d want %h/%0d", r, bus.data_o, bus.count_o, e.data, e.cnt); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        int   bad;
        exp_t e;
        bus.ready_i = 1'b0;
        send_beat(fill(11), 1'b0);
        send_beat(fill(-4), 1'b1);
        wait_valid(lat);
        checks++;
        if (!bus.valid_o || q.size() == 0) begin
            failures++; $display("FAIL backpressure valid_o got %b want 1 (timeout)", bus.valid_o);
        end else begin
            e = q.pop_front();
            bus.data_i = fill(50); bus.valid_i = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                checks += 2;
                if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1) begin failures++; $display("FAIL bp_hold cycle %0d ready_o/valid_o got %b/%b want 0/1", c, bus.ready_o, bus.valid_o); end
                bad = (bus.data_o !== e.data || bus.count_o !== e.cnt || bus.argmax_o !== e.idx || bus.overflow_o !== e.ovf) ? 1 : 0;
                if (bad != 0) begin failures++; $display("FAIL bp_stable cycle %0d data_o got %h want %h count got %0d want %0d", c, bus.data_o, e.data, bus.count_o, e.cnt); end
            end
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL bp_release ready_o/valid_o got %b/%b want 1/0", bus.ready_o, bus.valid_o); end
        send_beat(fill(6), 1'b1);
        wait_valid(lat);
        checks++;
        if (!bus.valid_o || q.size() == 0) begin
            failures++; $display("FAIL bp_next valid_o got %b want 1 (timeout)", bus.valid_o);
        end else begin
            e = q.pop_front();
            checks++;
            if (bus.count_o !== e.cnt || bus.data_o !== e.data) begin failures++; $display("FAIL bp_next count/data got %0d/%h want %0d/%h", bus.count_o, bus.data_o, e.cnt, e.data); end
        end
        @(posedge clk); #1;
    endtask

    // Long frame: saturates elements 0/1 and the beat counter; gaps carry a stray last_i.
    task automatic test_saturation();
        int   lat;
        exp_t e;
        vin_t v;
        for (int b = 0; b < 300; b++) begin
            for (int i = 2; i < VL; i++) v[i*BW_I +: BW_I] = BW_I'(longint'($urandom_range(0, 2000)) - 1000);
            v[0*BW_I +: BW_I] = BW_I'((longint'(1) <<< (BW_I - 1)) - 1);
            v[1*BW_I +: BW_I] = BW_I'(-(longint'(1) <<< (BW_I - 1)));
            send_beat(v, b == 299);
            if (b % 50 == 10) idle(2, 1'b1);
        end
        wait_valid(lat);
        checks++;
        if (!bus.valid_o || q.size() == 0) begin
            failures++; $display("FAIL saturation valid_o got %b want 1 (timeout)", bus.valid_o);
        end else begin
            e = q.pop_front();
            checks += 4;
            if (bus.data_o !== e.data) begin failures++; $display("FAIL saturation data_o got %h want %h", bus.data_o, e.data); end
            if (bus.overflow_o !== e.ovf) begin failures++; $display("FAIL saturation overflow_o got %b want %b", bus.overflow_o, e.ovf); end
            if (bus.count_o !== e.cnt) begin failures++; $display("FAIL count_sat count_o got %0d want %0d", bus.count_o, e.cnt); end
            if (bus.argmax_o !== e.idx) begin failures++; $display("FAIL saturation argmax_o got %0d want %0d", bus.argmax_o, e.idx); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   n;
        exp_t e;
        vin_t v;
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < VL; i++) v[i*BW_I +: BW_I] = BW_I'({$urandom, $urandom});
                send_beat(v, b == n - 1);
            end
            wait_valid(lat);
            checks++;
            if (!bus.valid_o || q.size() == 0) begin
                failures++; $display("FAIL b2b%0d valid_o got %b want 1 (timeout)", f, bus.valid_o);
            end else begin
                e = q.pop_front();
                checks += 3;
                if (bus.data_o !== e.data) begin failures++; $display("FAIL b2b%0d data_o got %h want %h", f, bus.data_o, e.data); end
                if (bus.argmax_o !== e.idx) begin failures++; $display("FAIL b2b%0d argmax_o got %0d want %0d", f, bus.argmax_o, e.idx); end
                if (bus.count_o !== e.cnt || bus.overflow_o !== e.ovf) begin failures++; $display("FAIL b2b%0d count/ovf got %0d/%b want %0d/%b", f, bus.count_o, bus.overflow_o, e.cnt, e.ovf); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        int   lat;
        exp_t e;
        send_beat(fill(9), 1'b0);
        send_beat(fill(9), 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        model_clear();
        checks += 3;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0) begin failures++; $display("FAIL async_rst valid_o/ready_o got %b/%b want 0/0", bus.valid_o, bus.ready_o); end
        if (bus.data_o !== '0) begin failures++; $display("FAIL async_rst data_o got %h want 0", bus.data_o); end
        if (bus.count_o !== '0 || bus.argmax_o !== '0 || bus.overflow_o !== 1'b0) begin failures++; $display("FAIL async_rst count/argmax/ovf got %0d/%0d/%b want 0/0/0", bus.count_o, bus.argmax_o, bus.overflow_o); end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL async_release ready_o got %b want 1", bus.ready_o); end
        @(posedge clk); #1;
        send_beat(fill(3), 1'b1);
        wait_valid(lat);
        checks++;
        if (!bus.valid_o || q.size() == 0) begin
            failures++; $display("FAIL async_after valid_o got %b want 1 (timeout)", bus.valid_o);
        end else begin
            e = q.pop_front();
            checks += 2;
            if (bus.data_o !== e.data) begin failures++; $display("FAIL async_after data_o got %h want %h", bus.data_o, e.data); end
            if (bus.count_o !== e.cnt || bus.overflow_o !== e.ovf) begin failures++; $display("FAIL async_after count/ovf got %0d/%b want %0d/%b", bus.count_o, bus.overflow_o, e.cnt, e.ovf); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();
        test_reset();
        test_basic();
        test_argmax();
        test_backpressure();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
